rng_regfile: RTL and testbench
==============================

# rng_regfile

Parametrised multi-bank operand register file for the 8-bit ALU datapath. Each bank supplies one ALU operand. In every bank, address 0 is hard-wired zero and address 1 is a per-bank Fibonacci LFSR. The LFSR advances synchronously on a qualified read and can be reseeded by a write. The block replaces the fixed two-bank design: bank count, depth, width and taps are parameters, and the clock-edge behaviour of the random register is fully defined.

## Interface
- WIDTH, 8, data width in bits (≥ 3)
- DEPTH, 8, registers per bank (≥ 2, power of two); AW = $clog2(DEPTH)
- BANKS, 2, number of banks, each with one read port (≥ 1); BW = max(1, $clog2(BANKS))
- TAPS, 8'hB8, LFSR feedback mask, WIDTH bits (default polynomial x^8+x^6+x^5+x^4+1, maximal)
- SEED, 1, reset seed of bank 0; bank b resets to (SEED + b) mod 2^WIDTH
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- wr_en  input  1  write strobe
- wr_bank  input  BW  write target bank
- wr_addr  input  AW  write target register
- wr_data  input  WIDTH  write data
- rd_en  input  BANKS  per-bank read qualifier; used only to advance the LFSR
- rd_addr  input  BANKS*AW  per-bank read address; bank b occupies bits [b*AW +: AW]
- rd_data  output  BANKS*WIDTH  per-bank read data; bank b occupies bits [b*WIDTH +: WIDTH]

## Operation
- Reads are combinational.
  - rd_addr = 0 returns 0.
  - rd_addr = 1 returns the current LFSR state of that bank.
  - Any other address returns the stored register.
- Writes occur on the clock edge when wr_en = 1.
  - Address 0: the write is ignored.
  - Address 1: the LFSR is loaded with wr_data. A zero value is replaced by 1 (lock-up guard).
  - Any other address: the register is loaded with wr_data.
  - wr_bank ≥ BANKS: the write is ignored.
- LFSR step, per bank, on the clock edge when rd_en[b] = 1 and rd_addr[b] = 1:
  - fb = ^(state & TAPS)
  - state <= {state[WIDTH-2:0], fb}
- No other condition advances the LFSR. In particular, an address change alone does not advance it.
- Simultaneous seed write and step on the same bank: the write wins and the step is dropped.
- A write and a step on different banks proceed independently.
- Simultaneous write and read of the same register: rd_data shows the old value in that cycle and the new value from the next cycle.
- Reset seed: if (SEED + b) mod 2^WIDTH = 0, that bank resets to 1.
- The LFSR state is never 0.

## Timing
- Asynchronous reset assertion, for the whole block:
  - every stored register is cleared to 0
  - every LFSR is loaded with its reset seed
  - rd_data follows immediately, combinationally
- Reset may assert mid-operation. Any write or step in flight at that edge is lost.
- rd_data is combinational from rd_addr: zero-cycle latency.
- Writes and LFSR steps have one-cycle latency: visible on rd_data after the capturing edge.
- With rd_en held high on address 1, the LFSR advances one step per clock. With default parameters the sequence has period 2^WIDTH − 1 = 255.
- There is no handshake and no stall. Every edge is independent.

## Structure
- Package rng_regfile_pkg contains:
  - the default TAPS localparam
  - ZERO_ADDR = 0 and RNG_ADDR = 1
  - the function lfsr_next(state, taps)
- Sub-module lfsr_chan, instantiated once per bank via a generate loop. It owns:
  - the state register and its reset to the per-bank seed
  - the zero-guarded load
  - the step enable
  - load-over-step priority
- Storage for addresses 2..DEPTH−1 is a per-bank array in the top module. Addresses 0 and 1 are not stored in this array.

## Test plan
All scenarios use default parameters.
- Reset: rd_addr = 1 on both banks → rd_data = 0x01 (bank 0) and 0x02 (bank 1). rd_addr = 0 → 0x00. rd_addr = 5 → 0x00.
- Stepping: hold rd_en[0] = 1, rd_addr[0] = 1 for 4 clocks → bank 0 shows 0x02, 0x04, 0x08, 0x11. Bank 1 stays at 0x02. After 255 steps bank 0 returns to 0x01, and 0x00 never appears.
- Address change alone: toggle rd_addr[0] between 1 and 3 with rd_en[0] = 0 for 10 cycles → LFSR unchanged.
- Writes:
  - write 0xA5 to bank 1, address 3 → visible next cycle; bank 0 address 3 stays 0x00
  - write 0x77 to address 0 → still reads 0x00
  - wr_bank beyond the bank range (needs BANKS = 3) → no change
- Seed priority:
  - same cycle, write 0x00 to bank 0 address 1 while stepping bank 0 → next value 0x01, step dropped
  - write 0x80 → the following step gives 0x01 (fb = 1)
- Reset mid-stream: after 7 steps plus writes, pulse rst_n low between edges → all outputs return to reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/rng_regfile_pkg.sv
// Shared constants and the LFSR next-state function for the operand register file.
// Pure definitions; no state, no latency, no backpressure.
// Widths up to MAX_W bits are supported by lfsr_next.
package rng_regfile_pkg;

    localparam logic [7:0] DEFAULT_TAPS = 8'hB8;
    localparam int         ZERO_ADDR    = 0;
    localparam int         RNG_ADDR     = 1;
    localparam int         MAX_W        = 64;

    // Fibonacci step: parity of tapped bits shifts in at the LSB.
    function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] state,
                                                   input logic [MAX_W-1:0] taps,
                                                   input int               width);
        logic             fb;
        logic [MAX_W-1:0] mask;
        fb   = ^(state & taps);
        mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        return ((state << 1) | MAX_W'(fb)) & mask;
    endfunction

endpackage

// File: rtl/lfsr_chan.sv
// One bank's random register: Fibonacci LFSR with zero-guarded load and step.
// Load/step visible one cycle after the capturing edge; reset is immediate.
// No backpressure: load beats step on the same edge, the step is dropped.
module lfsr_chan
    import rng_regfile_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] RST_SEED = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_en,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             step_en,
    output logic [WIDTH-1:0] state
);

    // An all-zero state would lock the register up forever.
    localparam logic [WIDTH-1:0] RST_VAL = (RST_SEED == '0) ? WIDTH'(1) : RST_SEED;

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (ld_en) begin
            state_d = (ld_data == '0) ? WIDTH'(1) : ld_data;
        end else if (step_en) begin
            state_d = WIDTH'(lfsr_next(MAX_W'(state_q), MAX_W'(TAPS), WIDTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/rng_regfile.sv
// Multi-bank operand register file: addr 0 reads zero, addr 1 is a per-bank LFSR.
// Reads are combinational; writes and LFSR steps land on the next clock edge.
// No handshake or stall; out-of-range bank writes are dropped.
module rng_regfile
    import rng_regfile_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 8,
    parameter int               BANKS = 2,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
    parameter int               SEED  = 1,
    localparam int              AW    = $clog2(DEPTH),
    localparam int              BW    = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [BW-1:0]          wr_bank,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic [BANKS-1:0]       rd_en,
    input  logic [BANKS*AW-1:0]    rd_addr,
    output logic [BANKS*WIDTH-1:0] rd_data
);

    // Addresses 0 and 1 have no storage; slot s holds address s+2.
    localparam int STORE = (DEPTH > 2) ? DEPTH - 2 : 1;

    logic [WIDTH-1:0] mem_q [BANKS][STORE];
    logic [WIDTH-1:0] mem_d [BANKS][STORE];

    always_comb begin
        mem_d = mem_q;
        for (int b = 0; b < BANKS; b++) begin
            for (int a = 2; a < DEPTH; a++) begin
                if (wr_en && (wr_bank == BW'(b)) && (wr_addr == AW'(a))) begin
                    mem_d[b][a-2] = wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < BANKS; b++) begin
                for (int s = 0; s < STORE; s++) begin
                    mem_q[b][s] <= '0;
                end
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        logic [AW-1:0]    ra;
        logic             step_en;
        logic             ld_en;
        logic [WIDTH-1:0] lfsr_state;
        logic [WIDTH-1:0] rd_val;

        assign ra      = rd_addr[g*AW +: AW];
        assign step_en = rd_en[g] && (ra == AW'(RNG_ADDR));
        assign ld_en   = wr_en && (wr_bank == BW'(g)) && (wr_addr == AW'(RNG_ADDR));

        lfsr_chan #(
            .WIDTH    (WIDTH),
            .TAPS     (TAPS),
            .RST_SEED (WIDTH'(SEED + g))
        ) u_lfsr (
            .clk     (clk),
            .rst_n   (rst_n),
            .ld_en   (ld_en),
            .ld_data (wr_data),
            .step_en (step_en),
            .state   (lfsr_state)
        );

        always_comb begin
            rd_val = '0;
            if (ra == AW'(RNG_ADDR)) begin
                rd_val = lfsr_state;
            end else begin
                for (int a = 2; a < DEPTH; a++) begin
                    if (ra == AW'(a)) begin
                        rd_val = mem_q[g][a-2];
                    end
                end
            end
        end

        assign rd_data[g*WIDTH +: WIDTH] = rd_val;
    end

endmodule

// File: tb/tb_rng_regfile.sv
// Self-checking bench for rng_regfile: vector table, corner sequences, random vs model.
module tb_rng_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [0:0]  wr_bank;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  rd_en;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data;

    logic        wr_en3;
    logic [1:0]  wr_bank3;
    logic [2:0]  wr_addr3;
    logic [7:0]  wr_data3;
    logic [2:0]  rd_en3;
    logic [8:0]  rd_addr3;
    logic [23:0] rd_data3;

    int checks = 0;
    int errors = 0;

    int unsigned m_lfsr [2];
    int unsigned m_mem  [2][8];

    always #5 clk = ~clk;

    rng_regfile dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    rng_regfile #(.BANKS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en3), .wr_bank(wr_bank3), .wr_addr(wr_addr3),
        .wr_data(wr_data3), .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3)
    );

    typedef struct {
        logic       we;
        logic       wb;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [1:0] re;
        logic [2:0] ra0;
        logic [2:0] ra1;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference step from the polynomial definition: parity of taps 0xB8 enters at bit 0.
    function automatic int unsigned ref_step(input int unsigned s);
        int unsigned fb;
        fb = $countones(s & 32'hB8) % 2;
        return ((s * 2) % 256) + fb;
    endfunction

    function automatic int unsigned mread(input int b, input int a);
        if (a == 0) return 0;
        if (a == 1) return m_lfsr[b];
        return m_mem[b][a];
    endfunction

    function automatic void model_reset();
        m_lfsr[0] = 1;
        m_lfsr[1] = 2;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 8; a++)
                m_mem[b][a] = 0;
    endfunction

    task automatic idle_inputs();
        wr_en = 0; wr_bank = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = {3'd1, 3'd1};
        wr_en3 = 0; wr_bank3 = 0; wr_addr3 = 0; wr_data3 = 0; rd_en3 = 0; rd_addr3 = '0;
    endtask

    // Advance the model from the current inputs, then let the DUT see one rising edge.
    task automatic tick();
        for (int b = 0; b < 2; b++) begin
            int ra;
            ra = int'(rd_addr[b*3 +: 3]);
            if (wr_en && int'(wr_bank) == b && wr_addr == 3'd1)
                m_lfsr[b] = (wr_data == 8'd0) ? 1 : int'(wr_data);
            else if (rd_en[b] && ra == 1)
                m_lfsr[b] = ref_step(m_lfsr[b]);
        end
        if (wr_en && wr_addr >= 3'd2)
            m_mem[wr_bank][wr_addr] = int'(wr_data);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic check_model(input string name);
        check({name, "_b0"}, {24'd0, rd_data[7:0]},  mread(0, int'(rd_addr[2:0])));
        check({name, "_b1"}, {24'd0, rd_data[15:8]}, mread(1, int'(rd_addr[5:3])));
    endtask

    initial begin
        int zero_seen;
        int first_ret;
        int unsigned held;

        //          we    wb    wa    wd     re     ra0   ra1   e0     e1
        tbl[0]  = '{1'b0, 1'b0, 3'd0, 8'h00, 2'b00, 3'd1, 3'd1, 8'h01, 8'h02};
        tbl[1]  = '{1'b0, 1'b0, 3'd0, 8'h00, 2'b01, 3'd1, 3'd1, 8'h01, 8'h02};
        tbl[2]  = '{1'b0, 1'b0, 3'd0, 8'h00, 2'b01, 3'd1, 3'd1, 8'h02, 8'h02};
        tbl[3]  = '{1'b0, 1'b0, 3'd0, 8'h00, 2'b01, 3'd1, 3'd1, 8'h04, 8'h02};
        tbl[4]  = '{1'b0, 1'b0, 3'd0, 8'h00, 2'b01, 3'd1, 3'd1, 8'h08, 8'h02};
        tbl[5]  = '{1'b0, 1'b0, 3'd0, 8'h00, 2'b00, 3'd1, 3'd1, 8'h11, 8'h02};
        tbl[6]  = '{1'b1, 1'b1, 3'd3, 8'hA5, 2'b00, 3'd3, 3'd3, 8'h00, 8'h00};
        tbl[7]  = '{1'b0, 1'b0, 3'd0, 8'h00, 2'b00, 3'd3, 3'd3, 8'h00, 8'hA5};
        tbl[8]  = '{1'b1, 1'b0, 3'd0, 8'h77, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00};
        tbl[9]  = '{1'b0, 1'b0, 3'd0, 8'h00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00};
        tbl[10] = '{1'b1, 1'b0, 3'd1, 8'h00, 2'b01, 3'd1, 3'd1, 8'h11, 8'h02};
        tbl[11] = '{1'b0, 1'b0, 3'd0, 8'h00, 2'b00, 3'd1, 3'd1, 8'h01, 8'h02};
        tbl[12] = '{1'b1, 1'b0, 3'd1, 8'h80, 2'b00, 3'd1, 3'd1, 8'h01, 8'h02};
        tbl[13] = '{1'b0, 1'b0, 3'd0, 8'h00, 2'b01, 3'd1, 3'd1, 8'h80, 8'h02};
        tbl[14] = '{1'b0, 1'b0, 3'd0, 8'h00, 2'b00, 3'd1, 3'd1, 8'h01, 8'h02};
        tbl[15] = '{1'b1, 1'b1, 3'd1, 8'h5A, 2'b11, 3'd1, 3'd1, 8'h01, 8'h02};
        tbl[16] = '{1'b0, 1'b0, 3'd0, 8'h00, 2'b00, 3'd1, 3'd1, 8'h02, 8'h5A};
        tbl[17] = '{1'b1, 1'b0, 3'd7, 8'h3C, 2'b00, 3'd7, 3'd3, 8'h00, 8'hA5};
        tbl[18] = '{1'b0, 1'b0, 3'd0, 8'h00, 2'b00, 3'd7, 3'd7, 8'h3C, 8'h00};

        do_reset();

        // Reset values
        rd_addr = {3'd1, 3'd1}; #1;
        check("rst_rng_b0", {24'd0, rd_data[7:0]}, 32'h01);
        check("rst_rng_b1", {24'd0, rd_data[15:8]}, 32'h02);
        rd_addr = {3'd0, 3'd0}; #1;
        check("rst_zero", {16'd0, rd_data}, 32'h0000);
        rd_addr = {3'd5, 3'd5}; #1;
        check("rst_addr5", {16'd0, rd_data}, 32'h0000);

        // Directed vector table
        for (int i = 0; i < 19; i++) begin
            wr_en = tbl[i].we; wr_bank = tbl[i].wb; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            rd_en = tbl[i].re; rd_addr = {tbl[i].ra1, tbl[i].ra0};
            #1;
            check($sformatf("vec%0d_b0", i), {24'd0, rd_data[7:0]},  {24'd0, tbl[i].e0});
            check($sformatf("vec%0d_b1", i), {24'd0, rd_data[15:8]}, {24'd0, tbl[i].e1});
            tick();
        end
        idle_inputs();

        // Address changes without a qualified read must not advance the LFSR
        held = m_lfsr[0];
        for (int i = 0; i < 10; i++) begin
            rd_en = 2'b00; rd_addr = {3'd1, (i % 2 == 1) ? 3'd3 : 3'd1};
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            rd_en = 2'b01; rd_addr = {3'd1, 3'd3};
            tick();
        end
        rd_en = 2'b00; rd_addr = {3'd1, 3'd1}; #1;
        check("addr_toggle_hold", {24'd0, rd_data[7:0]}, held);

        // Full period on bank 0
        do_reset();
        zero_seen = 0;
        first_ret = 0;
        rd_en = 2'b01; rd_addr = {3'd1, 3'd1};
        for (int i = 1; i <= 255; i++) begin
            tick();
            #1;
            if (rd_data[7:0] == 8'h00) zero_seen++;
            if (rd_data[7:0] == 8'h01 && first_ret == 0) first_ret = i;
            check($sformatf("period_step%0d", i), {24'd0, rd_data[7:0]}, m_lfsr[0]);
        end
        check("period_no_zero", zero_seen, 0);
        check("period_len", first_ret, 255);
        check("period_b1_idle", {24'd0, rd_data[15:8]}, 32'h02);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            wr_en   = ($urandom % 3) == 0;
            wr_bank = 1'($urandom);
            wr_addr = 3'($urandom);
            wr_data = (($urandom % 8) == 0) ? 8'h00 : 8'($urandom);
            rd_en   = 2'($urandom);
            rd_addr[2:0] = (($urandom % 2) == 0) ? 3'd1 : 3'($urandom);
            rd_addr[5:3] = (($urandom % 2) == 0) ? 3'd1 : 3'($urandom);
            #1;
            check_model($sformatf("rand%0d", i));
            tick();
        end

        // Asynchronous reset mid-stream, with a write pending at the next edge
        do_reset();
        rd_en = 2'b01; rd_addr = {3'd1, 3'd1};
        for (int i = 0; i < 7; i++) tick();
        rd_en = 2'b00;
        wr_en = 1; wr_bank = 1; wr_addr = 3'd3; wr_data = 8'h5C; tick();
        wr_bank = 0; wr_addr = 3'd6; wr_data = 8'h33; tick();
        wr_bank = 1; wr_addr = 3'd1; wr_data = 8'h40; tick();
        wr_bank = 0; wr_addr = 3'd3; wr_data = 8'hEE; rd_en = 2'b11;
        rd_addr = {3'd3, 3'd6}; #1;
        check("pre_rst_b0", {24'd0, rd_data[7:0]}, 32'h33);
        check("pre_rst_b1", {24'd0, rd_data[15:8]}, 32'h5C);
        #1 rst_n = 0;
        #1;
        check("async_rst_mem", {16'd0, rd_data}, 32'h0000);
        rd_addr = {3'd1, 3'd1}; #1;
        check("async_rst_rng", {16'd0, rd_data}, 32'h0201);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        model_reset();
        rd_addr = {3'd1, 3'd3}; #1;
        check("rst_write_lost", {24'd0, rd_data[7:0]}, 32'h00);
        check("rst_rng_b1_after", {24'd0, rd_data[15:8]}, 32'h02);

        // Three-bank instance: out-of-range bank writes are ignored
        rd_addr3 = {3'd1, 3'd1, 3'd1}; #1;
        check("b3_rst_seeds", {8'd0, rd_data3}, 32'h030201);
        wr_en3 = 1; wr_bank3 = 2'd3; wr_addr3 = 3'd3; wr_data3 = 8'h99; tick();
        wr_addr3 = 3'd1; tick();
        wr_en3 = 0;
        rd_addr3 = {3'd3, 3'd3, 3'd3}; #1;
        check("b3_oob_mem", {8'd0, rd_data3}, 32'h000000);
        rd_addr3 = {3'd1, 3'd1, 3'd1}; #1;
        check("b3_oob_rng", {8'd0, rd_data3}, 32'h030201);
        wr_en3 = 1; wr_bank3 = 2'd2; wr_addr3 = 3'd4; wr_data3 = 8'h42; tick();
        wr_en3 = 0;
        rd_addr3 = {3'd4, 3'd4, 3'd4}; #1;
        check("b3_bank2_write", {8'd0, rd_data3}, 32'h420000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
